// File: rtl/float_accumulator_bf16.sv
// ==== float_accumulator_bf16 : streaming bf16 accumulator, truncating add, no subnormals/Inf/NaN ====
// ==== Rev 1.0                                                                                    ====
`default_nettype none
module float_accumulator_bf16 #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             in_ready_q, out_valid_q, last_q;
  logic [15:0]      acc_q, op_q, out_data_q;
  logic [CNT_W-1:0] cnt_q, out_count_q;
  logic [7:0]       big_e_q, big_m_q, sml_m_q;
  logic             big_s_q, sml_s_q;
  logic [8:0]       sum_q;
  logic [7:0]       exp_q;
  logic             sign_q;

  // Alignment of accumulator (a) against the new operand (b)
  logic [7:0] a_e_d, b_e_d, a_m_d, b_m_d, big_e_d, big_m_d, sml_e_d, sml_m_d, diff_d, sml_sh_d;
  logic       a_big_d, big_s_d, sml_s_d;

  always_comb begin
    a_e_d    = (acc_q[14:7] == 8'hFF) ? 8'hFE : acc_q[14:7];
    b_e_d    = (op_q[14:7] == 8'hFF) ? 8'hFE : op_q[14:7];
    a_m_d    = (acc_q[14:7] == 8'h00) ? 8'h00 :
               (acc_q[14:7] == 8'hFF) ? 8'hFF : {1'b1, acc_q[6:0]};
    b_m_d    = (op_q[14:7] == 8'h00) ? 8'h00 :
               (op_q[14:7] == 8'hFF) ? 8'hFF : {1'b1, op_q[6:0]};
    a_big_d  = (a_e_d >= b_e_d);
    big_e_d  = a_big_d ? a_e_d : b_e_d;
    big_m_d  = a_big_d ? a_m_d : b_m_d;
    big_s_d  = a_big_d ? acc_q[15] : op_q[15];
    sml_e_d  = a_big_d ? b_e_d : a_e_d;
    sml_m_d  = a_big_d ? b_m_d : a_m_d;
    sml_s_d  = a_big_d ? op_q[15] : acc_q[15];
    diff_d   = big_e_d - sml_e_d;
    sml_sh_d = (diff_d >= 8'd8) ? 8'h00 : (sml_m_d >> diff_d[2:0]);
  end

  logic [8:0] sum_d;
  logic       sign_d;

  always_comb begin
    sum_d  = 9'd0;
    sign_d = big_s_q;
    if (big_s_q == sml_s_q) begin
      sum_d = {1'b0, big_m_q} + {1'b0, sml_m_q};
    end else if (big_m_q >= sml_m_q) begin
      sum_d = {1'b0, big_m_q} - {1'b0, sml_m_q};
    end else begin
      sum_d  = {1'b0, sml_m_q} - {1'b0, big_m_q};
      sign_d = sml_s_q;
    end
  end

  // One normalisation step; a left shift that lands on bit 7 exits in the same cycle
  logic        norm_exit_d;
  logic [15:0] norm_res_d;
  logic [7:0]  exp_m1_d, exp_p1_d, sh_d;

  always_comb begin
    exp_m1_d    = exp_q - 8'd1;
    exp_p1_d    = exp_q + 8'd1;
    sh_d        = {sum_q[6:0], 1'b0};
    norm_exit_d = 1'b1;
    norm_res_d  = 16'h0000;
    if (sum_q[8]) begin
      norm_res_d = (exp_q >= 8'd254) ? {sign_q, 15'h7F7F} : {sign_q, exp_p1_d, sum_q[7:1]};
    end else if (sum_q[7]) begin
      norm_res_d = {sign_q, exp_q, sum_q[6:0]};
    end else if ((sum_q == 9'd0) || (exp_m1_d == 8'd0)) begin
      norm_res_d = 16'h0000;
    end else if (sh_d[7]) begin
      norm_res_d = {sign_q, exp_m1_d, sh_d[6:0]};
    end else begin
      norm_exit_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_count_q <= '0;
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      op_q        <= 16'h0000;
      last_q      <= 1'b0;
      big_e_q     <= 8'h00;
      big_m_q     <= 8'h00;
      sml_m_q     <= 8'h00;
      big_s_q     <= 1'b0;
      sml_s_q     <= 1'b0;
      sum_q       <= 9'd0;
      exp_q       <= 8'h00;
      sign_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= in_data;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= ALIGN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ALIGN: begin
          big_e_q <= big_e_d;
          big_m_q <= big_m_d;
          big_s_q <= big_s_d;
          sml_m_q <= sml_sh_d;
          sml_s_q <= sml_s_d;
          state_q <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          sign_q  <= sign_d;
          exp_q   <= big_e_q;
          state_q <= NORM;
        end
        NORM: begin
          if (norm_exit_d) begin
            acc_q <= norm_res_d;
            cnt_q <= cnt_q + c_CNT_ONE;
            if (last_q) begin
              out_valid_q <= 1'b1;
              out_data_q  <= norm_res_d;
              out_count_q <= cnt_q + c_CNT_ONE;
              state_q     <= DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end else begin
            sum_q <= {1'b0, sh_d};
            exp_q <= exp_m1_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_float_accumulator_bf16.sv
// ==== tb_float_accumulator_bf16 : scoreboard bench with an arithmetic bf16 reference model ====
// ==== Rev 1.0                                                                              ====
`default_nettype none
module tb_float_accumulator_bf16;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [15:0]      in_data;
  logic             in_valid, in_last, in_ready;
  logic [15:0]      out_data;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] out_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]      data;
    logic [CNT_W-1:0] count;
  } exp_t;
  exp_t sb[$];

  logic        rnd_ready = 1'b0;
  logic [15:0] m_acc = 16'h0000;
  int          m_cnt = 0;

  float_accumulator_bf16 #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Value-level sum: decode, align as integers, add signed, renormalise
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, s, mag;
    bit neg;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0) ma = 0; else if (ea == 255) begin ea = 254; ma = 255; end else ma = 128 + int'(a[6:0]);
    if (eb == 0) mb = 0; else if (eb == 255) begin eb = 254; mb = 255; end else mb = 128 + int'(b[6:0]);
    if (ea >= eb) begin
      e  = ea;
      mb = (ea - eb >= 8) ? 0 : (mb >> (ea - eb));
    end else begin
      e  = eb;
      ma = (eb - ea >= 8) ? 0 : (ma >> (eb - ea));
    end
    s   = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    neg = (s < 0);
    mag = neg ? -s : s;
    if (mag == 0) return 16'h0000;
    if (mag >= 256) begin
      mag = mag / 2;
      e   = e + 1;
      if (e > 254) return {neg, 15'h7F7F};
    end
    while (mag < 128) begin
      mag = mag * 2;
      e   = e - 1;
      if (e == 0) return 16'h0000;
    end
    return {neg, e[7:0], mag[6:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 99);
    if (r < 10)      e = 8'h00;
    else if (r < 15) e = 8'hFF;
    else if (r < 20) e = 8'hFE;
    else if (r < 25) e = 8'($urandom_range(1, 3));
    else             e = 8'(120 + $urandom_range(0, 15));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic push_exp(input logic [15:0] d, input logic [CNT_W-1:0] c);
    exp_t x;
    x.data  = d;
    x.count = c;
    sb.push_back(x);
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      timeout("in_ready_wait");
      return;
    end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = 16'($urandom());
    @(negedge clock);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic add_op(input logic [15:0] d, input logic last);
    m_acc = ref_add(m_acc, d);
    m_cnt++;
    if (last) begin
      push_exp(m_acc, m_cnt[CNT_W-1:0]);
      m_acc = 16'h0000;
      m_cnt = 0;
    end
    send(d, last);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops on each accepted output, checks hold while stalled
  initial begin
    logic             stalled;
    logic [15:0]      hd;
    logic [CNT_W-1:0] hc;
    exp_t             x;
    stalled = 1'b0;
    hd      = 16'h0000;
    hc      = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else if (out_valid) begin
        if (stalled) begin
          check("hold_data", 32'(out_data), 32'(hd));
          check("hold_count", 32'(out_count), 32'(hc));
        end
        if (out_ready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data);
          end else begin
            x = sb.pop_front();
            check("sum_data", 32'(out_data), 32'(x.data));
            check("sum_count", 32'(out_count), 32'(x.count));
          end
        end else begin
          stalled = 1'b1;
          hd      = out_data;
          hc      = out_count;
        end
      end else begin
        if (stalled) check("valid_dropped", 32'(out_valid), 32'd1);
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int len;
    reset     = 1'b1;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    push_exp(16'h4040, 8'd2); send(16'h3F80, 1'b0); send(16'h4000, 1'b1);
    push_exp(16'h3F80, 8'd2); send(16'h4040, 1'b0); send(16'hC000, 1'b1);
    push_exp(16'h0000, 8'd2); send(16'h3F80, 1'b0); send(16'hBF80, 1'b1);
    push_exp(16'h7F7F, 8'd2); send(16'h7F7F, 1'b0); send(16'h7F7F, 1'b1);

    // Stalled output with a competing in_valid
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    @(posedge clock);
    #2 out_ready = 1'b0;
    push_exp(16'h0000, 8'd1);
    send(16'h0000, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clock); n++; end
    if (!out_valid) timeout("stall_out_valid_wait");
    in_data  = 16'h3F80;
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h0000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    rnd_ready = 1'b1;
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) add_op(rand_op(), i == len - 1);
    end
    for (int i = 0; i < 258; i++) add_op({1'b0, 8'(120 + $urandom_range(0, 7)), 7'($urandom_range(0, 127))}, i == 257);

    // Reset during NORM of the third operand abandons the sum
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clock); n++; end
    rnd_ready = 1'b0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4040, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_exp(16'h4000, 8'd1);
    send(16'h4000, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clock); n++; end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
